// File: rtl/leaf_out_arbiter_if.sv
// Bus bundle for the leaf output arbiter: user output streams, runtime routing
// config, credit returns and the registered BFT output link.
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_OUT_PORTS = 4
);
  localparam int SEL_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2arb;
  logic [NUM_OUT_PORTS-1:0]              vld_user2arb;
  logic [NUM_OUT_PORTS-1:0]              ack_arb2user;
  logic                                  cfg_we;
  logic [SEL_BITS-1:0]                   cfg_port;
  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf;
  logic [NUM_PORT_BITS-1:0]              cfg_dest_port;
  logic                                  cfg_en;
  logic                                  credit_vld;
  logic [SEL_BITS-1:0]                   credit_port;
  logic                                  stall;
  logic [PACKET_BITS-1:0]                dout_leaf_arb2bft;
  logic                                  credit_err;

  modport master (
    output din_leaf_user2arb, vld_user2arb, cfg_we, cfg_port, cfg_dest_leaf,
           cfg_dest_port, cfg_en, credit_vld, credit_port, stall,
    input  ack_arb2user, dout_leaf_arb2bft, credit_err
  );

  modport slave (
    input  din_leaf_user2arb, vld_user2arb, cfg_we, cfg_port, cfg_dest_leaf,
           cfg_dest_port, cfg_en, credit_vld, credit_port, stall,
    output ack_arb2user, dout_leaf_arb2bft, credit_err
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing one leaf-to-BFT link among user output streams,
// packetising words with per-stream routing, address counters and credits.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int CREDIT_INIT           = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic              clk,
  input logic              reset,
  leaf_out_arbiter_if.slave bus
);
  localparam int SEL_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CW       = NUM_ADDR_BITS + 1;

  logic [SEL_BITS-1:0]      ptr_q, ptr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     err_q;
  logic [NUM_OUT_PORTS-1:0] en_all, eligible, grant, overflow;
  logic [NUM_LEAF_BITS-1:0] leaf_all [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port_all [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_all [NUM_OUT_PORTS];
  logic                     gvld;
  logic [SEL_BITS-1:0]      gidx, cand;
  logic [PAYLOAD_BITS-1:0]  sel_word;
  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_port;
  logic [NUM_ADDR_BITS-1:0] sel_addr;

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_stream
    logic                     en_q;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] port_q;
    logic [NUM_ADDR_BITS-1:0] addr_q;
    logic [CW-1:0]            credit_q;
    logic                     cfg_hit, ret_hit;
    logic [CW:0]              credit_sum;

    assign cfg_hit = bus.cfg_we && (bus.cfg_port == SEL_BITS'(gi));
    // A credit return that collides with a config write is discarded.
    assign ret_hit = bus.credit_vld && (bus.credit_port == SEL_BITS'(gi)) && !cfg_hit;
    assign eligible[gi] = bus.vld_user2arb[gi] && en_q && (credit_q != '0) && !cfg_hit;
    assign credit_sum = {1'b0, credit_q} - (CW+1)'(grant[gi])
                      + (ret_hit ? (CW+1)'(FREESPACE_UPDATE_SIZE) : '0);
    assign overflow[gi] = credit_sum > (CW+1)'(CREDIT_INIT);

    assign en_all[gi]   = en_q;
    assign leaf_all[gi] = leaf_q;
    assign port_all[gi] = port_q;
    assign addr_all[gi] = addr_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        en_q     <= 1'b0;
        leaf_q   <= '0;
        port_q   <= '0;
        addr_q   <= '0;
        credit_q <= CW'(CREDIT_INIT);
      end else if (cfg_hit) begin
        en_q     <= bus.cfg_en;
        leaf_q   <= bus.cfg_dest_leaf;
        port_q   <= bus.cfg_dest_port;
        addr_q   <= '0;
        credit_q <= CW'(CREDIT_INIT);
      end else begin
        credit_q <= overflow[gi] ? CW'(CREDIT_INIT) : credit_sum[CW-1:0];
        if (grant[gi]) addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Search from the pointer; reset and stall both suppress the grant.
  always_comb begin
    gvld = 1'b0;
    gidx = ptr_q;
    cand = ptr_q;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      cand = SEL_BITS'((int'(ptr_q) + k) % NUM_OUT_PORTS);
      if (!gvld && !reset && !bus.stall && eligible[cand]) begin
        gvld = 1'b1;
        gidx = cand;
      end
    end
    grant = '0;
    if (gvld) grant[gidx] = 1'b1;
    ptr_d = gvld ? SEL_BITS'((int'(gidx) + 1) % NUM_OUT_PORTS) : ptr_q;
  end

  always_comb begin
    sel_word = '0;
    sel_leaf = '0;
    sel_port = '0;
    sel_addr = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (grant[k]) begin
        sel_word = bus.din_leaf_user2arb[k*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_leaf = leaf_all[k];
        sel_port = port_all[k];
        sel_addr = addr_all[k];
      end
    end
    if (bus.stall)   dout_d = dout_q;
    else if (gvld)   dout_d = {1'b1, sel_leaf, sel_port, sel_addr, sel_word};
    else             dout_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      dout_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
      err_q  <= err_q | (|overflow);
    end
  end

  assign bus.ack_arb2user      = grant;
  assign bus.dout_leaf_arb2bft = dout_q;
  assign bus.credit_err        = err_q;
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomised and directed checks of leaf_out_arbiter against a behavioural
// model of streams, credits, addresses and the round-robin order.
module tb_leaf_out_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  leaf_out_arbiter_if bif ();
  leaf_out_arbiter dut (.clk(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_en   [4];
  logic [4:0]  m_leaf [4];
  logic [3:0]  m_port [4];
  int          m_addr [4];
  int          m_credit [4];
  int          m_ptr;
  bit          m_err;
  logic [48:0] m_dout;

  logic [3:0]  ack_obs, ack_exp;
  logic [48:0] dout_obs, dout_exp;
  logic        err_obs, err_exp;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_leaf[i] = '0; m_port[i] = '0; m_addr[i] = 0; m_credit[i] = 128;
    end
    m_ptr = 0; m_err = 0; m_dout = '0;
  endfunction

  function automatic int model_grant();
    if (reset || bif.stall) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (bif.vld_user2arb[i] && m_en[i] && m_credit[i] > 0 &&
          !(bif.cfg_we && int'(bif.cfg_port) == i)) return i;
    end
    return -1;
  endfunction

  function automatic void model_update(int g);
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      int c;
      c = m_credit[i] - ((g == i) ? 1 : 0);
      if (bif.credit_vld && int'(bif.credit_port) == i && !(bif.cfg_we && int'(bif.cfg_port) == i))
        c += 64;
      if (c > 128) begin
        c = 128;
        m_err = 1;
      end
      m_credit[i] = c;
    end
    if (g >= 0) begin
      m_dout = {1'b1, m_leaf[g], m_port[g], 7'(m_addr[g]), bif.din_leaf_user2arb[g*32 +: 32]};
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_ptr = (g + 1) % 4;
    end else if (!bif.stall) begin
      m_dout = '0;
    end
    if (bif.cfg_we) begin
      m_en[bif.cfg_port]     = bif.cfg_en;
      m_leaf[bif.cfg_port]   = bif.cfg_dest_leaf;
      m_port[bif.cfg_port]   = bif.cfg_dest_port;
      m_addr[bif.cfg_port]   = 0;
      m_credit[bif.cfg_port] = 128;
    end
  endfunction

  // One clock: inputs already set at the falling edge; ack sampled before the
  // rising edge, dout/err sampled just after it; returns at the next falling edge.
  task automatic step();
    int g;
    #2;
    g = model_grant();
    ack_exp = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    ack_obs = bif.ack_arb2user;
    model_update(g);
    @(posedge clk);
    #1;
    dout_obs = bif.dout_leaf_arb2bft;
    err_obs  = bif.credit_err;
    dout_exp = m_dout;
    err_exp  = m_err;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bif.vld_user2arb = '0; bif.cfg_we = 0; bif.cfg_port = '0; bif.cfg_dest_leaf = '0;
    bif.cfg_dest_port = '0; bif.cfg_en = 0; bif.credit_vld = 0; bif.credit_port = '0;
    bif.stall = 0;
  endtask

  task automatic refresh_acked();
    for (int i = 0; i < 4; i++)
      if (ack_exp[i]) bif.din_leaf_user2arb[i*32 +: 32] = $urandom;
  endtask

  task automatic reset_cycle();
    reset = 1; step(); reset = 0;
  endtask

  task automatic cfg_stream(input int s, input logic [4:0] leaf, input logic [3:0] port, input bit en);
    bif.cfg_we = 1; bif.cfg_port = 2'(s); bif.cfg_dest_leaf = leaf; bif.cfg_dest_port = port;
    bif.cfg_en = en;
    step();
    bif.cfg_we = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    bif.vld_user2arb = 4'hF; bif.din_leaf_user2arb = {$urandom, $urandom, $urandom, $urandom};
    bif.credit_vld = 1;
    step();
    checks++; if (ack_obs !== 4'b0000) begin errors++; $display("FAIL reset_ack got %h expected 0", ack_obs); end
    checks++; if (dout_obs !== 49'd0) begin errors++; $display("FAIL reset_dout got %h expected 0", dout_obs); end
    checks++; if (err_obs !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err_obs); end
    idle_inputs();
    reset = 0;
    step();
    checks++; if (ack_obs !== 4'b0000) begin errors++; $display("FAIL reset_disabled_ack got %h expected 0", ack_obs); end
  endtask

  task automatic test_basic();
    cfg_stream(0, 5'd3, 4'd2, 1);
    bif.vld_user2arb = 4'b0001;
    bif.din_leaf_user2arb[31:0] = 32'hDEADBEEF;
    step();
    checks++; if (ack_obs !== 4'b0001) begin errors++; $display("FAIL basic_ack got %h expected 1", ack_obs); end
    checks++;
    if (dout_obs !== {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL basic_dout got %h expected %h", dout_obs, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
    end
    bif.din_leaf_user2arb[31:0] = 32'h12345678;
    step();
    checks++; if (dout_obs !== {1'b1, 5'd3, 4'd2, 7'd1, 32'h12345678}) begin
      errors++; $display("FAIL basic_addr1 got %h expected %h", dout_obs, {1'b1, 5'd3, 4'd2, 7'd1, 32'h12345678});
    end
    bif.vld_user2arb = 4'b0000;
    step();
    checks++; if (dout_obs[48] !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b expected 0", dout_obs[48]); end
  endtask

  task automatic test_round_robin();
    int cnt [4];
    reset_cycle();
    for (int i = 0; i < 4; i++) cfg_stream(i, 5'(i + 1), 4'(i), 1);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    bif.vld_user2arb = 4'hF;
    for (int c = 0; c < 100; c++) begin
      step();
      checks++; if (ack_obs !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL rr_order cycle %0d got %h expected %h", c, ack_obs, 4'b0001 << (c % 4)); end
      checks++; if (dout_obs !== dout_exp) begin errors++; $display("FAIL rr_dout cycle %0d got %h expected %h", c, dout_obs, dout_exp); end
      for (int i = 0; i < 4; i++) if (ack_obs[i]) cnt[i]++;
      refresh_acked();
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt[i] !== 25) begin errors++; $display("FAIL rr_share stream %0d got %0d expected 25", i, cnt[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_credit();
    int acc;
    bit first;
    reset_cycle();
    cfg_stream(0, 5'd7, 4'd1, 1);
    bif.vld_user2arb = 4'b0001;
    acc = 0;
    for (int c = 0; c < 130; c++) begin
      step();
      checks++; if (ack_obs !== ack_exp) begin errors++; $display("FAIL credit_ack cycle %0d got %h expected %h", c, ack_obs, ack_exp); end
      checks++; if (dout_obs !== dout_exp) begin errors++; $display("FAIL credit_dout cycle %0d got %h expected %h", c, dout_obs, dout_exp); end
      if (ack_obs[0]) acc++;
      refresh_acked();
    end
    checks++; if (acc !== 128) begin errors++; $display("FAIL credit_exhaust got %0d acks expected 128", acc); end
    bif.credit_vld = 1; bif.credit_port = 2'd0;
    step();
    bif.credit_vld = 0;
    checks++; if (ack_obs !== 4'b0000) begin errors++; $display("FAIL credit_zero_ack got %h expected 0", ack_obs); end
    acc = 0; first = 1;
    for (int c = 0; c < 70; c++) begin
      step();
      checks++; if (ack_obs !== ack_exp) begin errors++; $display("FAIL refill_ack cycle %0d got %h expected %h", c, ack_obs, ack_exp); end
      if (ack_obs[0]) begin
        if (first) begin
          checks++; if (dout_obs[38:32] !== 7'd0) begin errors++; $display("FAIL addr_wrap got %0d expected 0", dout_obs[38:32]); end
          first = 0;
        end
        acc++;
      end
      refresh_acked();
    end
    checks++; if (acc !== 64) begin errors++; $display("FAIL refill_count got %0d expected 64", acc); end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [48:0] held;
    reset_cycle();
    for (int i = 0; i < 4; i++) cfg_stream(i, 5'(i + 8), 4'(i + 4), 1);
    bif.vld_user2arb = 4'hF;
    for (int c = 0; c < 6; c++) begin step(); refresh_acked(); end
    held = dout_obs;
    bif.stall = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (ack_obs !== 4'b0000) begin errors++; $display("FAIL stall_ack cycle %0d got %h expected 0", c, ack_obs); end
      checks++; if (dout_obs !== held) begin errors++; $display("FAIL stall_hold cycle %0d got %h expected %h", c, dout_obs, held); end
    end
    bif.stall = 0;
    step();
    checks++; if (ack_obs !== 4'b0100) begin errors++; $display("FAIL stall_resume got %h expected 4", ack_obs); end
    checks++; if (dout_obs !== dout_exp) begin errors++; $display("FAIL stall_resume_dout got %h expected %h", dout_obs, dout_exp); end
    idle_inputs();
  endtask

  task automatic test_credit_overflow();
    int acc;
    reset_cycle();
    cfg_stream(1, 5'd2, 4'd9, 1);
    bif.vld_user2arb = 4'b0010;
    for (int c = 0; c < 127; c++) begin step(); refresh_acked(); end
    bif.credit_vld = 1; bif.credit_port = 2'd1;
    step();
    bif.credit_vld = 0;
    refresh_acked();
    checks++; if (ack_obs !== 4'b0010) begin errors++; $display("FAIL last_credit_ack got %h expected 2", ack_obs); end
    checks++; if (err_obs !== 1'b0) begin errors++; $display("FAIL simul_grant_err got %b expected 0", err_obs); end
    acc = 0;
    for (int c = 0; c < 70; c++) begin step(); if (ack_obs[1]) acc++; refresh_acked(); end
    checks++; if (acc !== 64) begin errors++; $display("FAIL simul_grant_credit got %0d acks expected 64", acc); end
    bif.vld_user2arb = 4'b0000;
    bif.credit_vld = 1; bif.credit_port = 2'd1;
    step(); step();
    checks++; if (err_obs !== 1'b0) begin errors++; $display("FAIL fill_to_max_err got %b expected 0", err_obs); end
    step();
    bif.credit_vld = 0;
    checks++; if (err_obs !== 1'b1) begin errors++; $display("FAIL overflow_err got %b expected 1", err_obs); end
    step(); step();
    checks++; if (err_obs !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", err_obs); end
    bif.vld_user2arb = 4'b0010;
    acc = 0;
    for (int c = 0; c < 131; c++) begin step(); if (ack_obs[1]) acc++; refresh_acked(); end
    checks++; if (acc !== 128) begin errors++; $display("FAIL clamp_credit got %0d acks expected 128", acc); end
    idle_inputs();
  endtask

  task automatic test_reset_traffic();
    reset_cycle();
    for (int i = 0; i < 4; i++) cfg_stream(i, 5'(i), 4'(i), 1);
    bif.vld_user2arb = 4'hF;
    for (int c = 0; c < 5; c++) begin step(); refresh_acked(); end
    reset = 1;
    step();
    reset = 0;
    checks++; if (ack_obs !== 4'b0000) begin errors++; $display("FAIL rst_traffic_ack got %h expected 0", ack_obs); end
    checks++; if (dout_obs !== 49'd0) begin errors++; $display("FAIL rst_traffic_dout got %h expected 0", dout_obs); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (ack_obs !== 4'b0000) begin errors++; $display("FAIL rst_disabled cycle %0d got %h expected 0", c, ack_obs); end
    end
    cfg_stream(2, 5'd17, 4'd3, 1);
    step();
    checks++; if (ack_obs !== 4'b0100) begin errors++; $display("FAIL rst_reconfig_ack got %h expected 4", ack_obs); end
    checks++; if (dout_obs !== {1'b1, 5'd17, 4'd3, 7'd0, bif.din_leaf_user2arb[95:64]}) begin
      errors++; $display("FAIL rst_reconfig_dout got %h expected %h", dout_obs, dout_exp);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    reset_cycle();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bif.cfg_we = ($urandom_range(0, 7) == 0);
      bif.cfg_port = 2'($urandom_range(0, 3));
      bif.cfg_dest_leaf = 5'($urandom);
      bif.cfg_dest_port = 4'($urandom);
      bif.cfg_en = ($urandom_range(0, 3) != 0);
      bif.credit_vld = ($urandom_range(0, 11) == 0);
      bif.credit_port = 2'($urandom_range(0, 3));
      bif.stall = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 4; i++)
        if (!bif.vld_user2arb[i] || ack_exp[i]) bif.vld_user2arb[i] = ($urandom_range(0, 2) != 0);
      step();
      checks++; if (ack_obs !== ack_exp) begin errors++; $display("FAIL rand_ack cycle %0d got %h expected %h", c, ack_obs, ack_exp); end
      checks++; if (dout_obs !== dout_exp) begin errors++; $display("FAIL rand_dout cycle %0d got %h expected %h", c, dout_obs, dout_exp); end
      checks++; if (err_obs !== err_exp) begin errors++; $display("FAIL rand_err cycle %0d got %b expected %b", c, err_obs, err_exp); end
      refresh_acked();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    bif.din_leaf_user2arb = '0;
    ack_exp = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_credit();
    test_stall();
    test_credit_overflow();
    test_reset_traffic();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
